// File: rtl/secure_elevator_ctrl_n.sv
// secure_elevator_ctrl_n: password-gated SCAN elevator controller with bad-password lockout.
// Defining FIRE_RECALL_EN adds the fire_recall input, which returns the car to floor 0.
//
// state     | meaning
// IDLE      | car parked, door closed, picks next direction from pending
// MOVE_UP   | motor up, travel timer running toward the next floor
// MOVE_DOWN | motor down, travel timer running toward the next floor
// DOOR      | door open, dwell timer running (held open at floor 0 during recall)
module secure_elevator_ctrl_n #(
  parameter int              FLOORS        = 8,
  parameter int              FLOOR_W       = 3,
  parameter int              PW_W          = 4,
  parameter logic [PW_W-1:0] PASSWORD      = 4'b1010,
  parameter int              MAX_FAILS     = 3,
  parameter int              LOCK_CYCLES   = 64,
  parameter int              TRAVEL_CYCLES = 4,
  parameter int              DOOR_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic [PW_W-1:0]    password,
`ifdef FIRE_RECALL_EN
  input  logic               fire_recall,
`endif
  output logic               req_ready,
  output logic               req_accept,
  output logic               req_reject,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               door_open,
  output logic               up,
  output logic               down,
  output logic               locked,
  output logic [FLOORS-1:0]  pending
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int TRAV_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t             state, state_nxt;
  logic               dir_up, dir_nxt;
  logic [FLOOR_W-1:0] floor_nxt, floor_up, floor_dn;
  logic [TRAV_W-1:0]  travel_tmr, travel_nxt;
  logic [DOOR_W-1:0]  door_tmr, door_nxt;
  logic [LOCK_W-1:0]  lock_tmr, lock_nxt;
  logic [FAIL_W-1:0]  fail_cnt, fail_nxt;
  logic [FLOORS-1:0]  pend_nxt, pend_req;
  logic [FLOORS-1:0]  above_cur, below_cur, above_up, below_dn;
  logic               locked_nxt, accept_nxt, reject_nxt, reopen, recall;

`ifdef FIRE_RECALL_EN
  assign recall = fire_recall;
`else
  assign recall = 1'b0;
`endif

  function automatic logic [FLOORS-1:0] mask_above(input logic [FLOOR_W-1:0] f);
    for (int i = 0; i < FLOORS; i++) mask_above[i] = (i > int'(f));
  endfunction

  function automatic logic [FLOORS-1:0] mask_below(input logic [FLOOR_W-1:0] f);
    for (int i = 0; i < FLOORS; i++) mask_below[i] = (i < int'(f));
  endfunction

  assign floor_up  = current_floor + FLOOR_W'(1);
  assign floor_dn  = current_floor - FLOOR_W'(1);
  assign above_cur = mask_above(current_floor);
  assign below_cur = mask_below(current_floor);
  assign above_up  = mask_above(floor_up);
  assign below_dn  = mask_below(floor_dn);

  assign req_ready = !locked;
  assign up        = (state == MOVE_UP);
  assign down      = (state == MOVE_DOWN);
  assign door_open = (state == DOOR);

  always_comb begin
    state_nxt  = state;
    floor_nxt  = current_floor;
    dir_nxt    = dir_up;
    travel_nxt = travel_tmr;
    door_nxt   = door_tmr;
    pend_nxt   = pending;
    fail_nxt   = fail_cnt;
    lock_nxt   = lock_tmr;
    locked_nxt = locked;
    accept_nxt = 1'b0;
    reject_nxt = 1'b0;
    reopen     = 1'b0;

    if (locked) begin
      if (lock_tmr <= LOCK_W'(1)) begin
        locked_nxt = 1'b0;
        lock_nxt   = '0;
        fail_nxt   = '0;
      end else begin
        lock_nxt = lock_tmr - LOCK_W'(1);
      end
    end

    // Out-of-range floors are rejected before the password is judged, so they never count as fails.
    if (req_valid && req_ready) begin
      if (recall || (32'(req_floor) >= 32'(FLOORS))) begin
        reject_nxt = 1'b1;
      end else if (password != PASSWORD) begin
        reject_nxt = 1'b1;
        fail_nxt   = fail_cnt + FAIL_W'(1);
        if (32'(fail_cnt) + 32'd1 >= 32'(MAX_FAILS)) begin
          locked_nxt = 1'b1;
          lock_nxt   = LOCK_W'(LOCK_CYCLES);
        end
      end else begin
        accept_nxt = 1'b1;
        fail_nxt   = '0;
        if ((state == IDLE || state == DOOR) && req_floor == current_floor) reopen = 1'b1;
        else pend_nxt[req_floor] = 1'b1;
      end
    end

    if (recall) pend_nxt = '0;
    pend_req = pend_nxt;

    unique case (state)
      IDLE: begin
        if (reopen || (recall && current_floor == '0)) begin
          state_nxt = DOOR;
          door_nxt  = DOOR_W'(DOOR_CYCLES);
        end else if (recall) begin
          state_nxt  = MOVE_DOWN;
          dir_nxt    = 1'b0;
          travel_nxt = TRAV_W'(TRAVEL_CYCLES);
        end else if (pending[current_floor]) begin
          pend_nxt[current_floor] = 1'b0;
          state_nxt = DOOR;
          door_nxt  = DOOR_W'(DOOR_CYCLES);
        end else if (|(pending & above_cur) && (dir_up || !(|(pending & below_cur)))) begin
          state_nxt  = MOVE_UP;
          dir_nxt    = 1'b1;
          travel_nxt = TRAV_W'(TRAVEL_CYCLES);
        end else if (|(pending & below_cur)) begin
          state_nxt  = MOVE_DOWN;
          dir_nxt    = 1'b0;
          travel_nxt = TRAV_W'(TRAVEL_CYCLES);
        end
      end
      MOVE_UP: begin
        if (travel_tmr > TRAV_W'(1)) begin
          travel_nxt = travel_tmr - TRAV_W'(1);
        end else begin
          floor_nxt  = floor_up;
          travel_nxt = TRAV_W'(TRAVEL_CYCLES);
          if (recall) begin
            state_nxt = MOVE_DOWN;
            dir_nxt   = 1'b0;
          end else if (pend_req[floor_up]) begin
            pend_nxt[floor_up] = 1'b0;
            state_nxt  = DOOR;
            door_nxt   = DOOR_W'(DOOR_CYCLES);
            travel_nxt = '0;
          end else if (!(|(pend_req & above_up))) begin
            state_nxt  = IDLE;
            travel_nxt = '0;
          end
        end
      end
      MOVE_DOWN: begin
        if (travel_tmr > TRAV_W'(1)) begin
          travel_nxt = travel_tmr - TRAV_W'(1);
        end else begin
          floor_nxt  = floor_dn;
          travel_nxt = TRAV_W'(TRAVEL_CYCLES);
          if (recall) begin
            if (floor_dn == '0) begin
              state_nxt  = DOOR;
              door_nxt   = DOOR_W'(DOOR_CYCLES);
              travel_nxt = '0;
            end
          end else if (pend_req[floor_dn]) begin
            pend_nxt[floor_dn] = 1'b0;
            state_nxt  = DOOR;
            door_nxt   = DOOR_W'(DOOR_CYCLES);
            travel_nxt = '0;
          end else if (!(|(pend_req & below_dn))) begin
            state_nxt  = IDLE;
            travel_nxt = '0;
          end
        end
      end
      DOOR: begin
        // Recall at floor 0 keeps reloading the dwell so a full dwell follows its release.
        if (reopen || (recall && current_floor == '0)) begin
          door_nxt = DOOR_W'(DOOR_CYCLES);
        end else if (recall || door_tmr <= DOOR_W'(1)) begin
          state_nxt = IDLE;
          door_nxt  = '0;
        end else begin
          door_nxt = door_tmr - DOOR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dir_up        <= 1'b1;
      current_floor <= '0;
      travel_tmr    <= '0;
      door_tmr      <= '0;
      lock_tmr      <= '0;
      fail_cnt      <= '0;
      locked        <= 1'b0;
      pending       <= '0;
      req_accept    <= 1'b0;
      req_reject    <= 1'b0;
    end else begin
      state         <= state_nxt;
      dir_up        <= dir_nxt;
      current_floor <= floor_nxt;
      travel_tmr    <= travel_nxt;
      door_tmr      <= door_nxt;
      lock_tmr      <= lock_nxt;
      fail_cnt      <= fail_nxt;
      locked        <= locked_nxt;
      pending       <= pend_nxt;
      req_accept    <= accept_nxt;
      req_reject    <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_secure_elevator_ctrl_n.sv
// Directed bench for secure_elevator_ctrl_n with response and stop-order scoreboards.
// Six floors so that out-of-range request floors are representable on the 3-bit port.
module tb_secure_elevator_ctrl_n;
  localparam int         FLOORS = 6;
  localparam int         FW     = 3;
  localparam logic [3:0] PW     = 4'b1010;
  localparam logic [3:0] BADPW  = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic [3:0] password = '0;
  logic req_ready, req_accept, req_reject, door_open, up, down, locked;
  logic [FW-1:0] current_floor;
  logic [FLOORS-1:0] pending;
`ifdef FIRE_RECALL_EN
  logic fire_recall = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int rsp_q[$];
  int stop_q[$];
  bit mon_on = 1'b0;
  logic door_prev = 1'b0;
  logic inv_ok;

  secure_elevator_ctrl_n #(.FLOORS(FLOORS), .FLOOR_W(FW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor), .password(password),
`ifdef FIRE_RECALL_EN
    .fire_recall(fire_recall),
`endif
    .req_ready(req_ready), .req_accept(req_accept), .req_reject(req_reject),
    .current_floor(current_floor), .door_open(door_open), .up(up), .down(down),
    .locked(locked), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; response codes: 1 accept, 0 reject.
  task automatic send(input int f, input logic [3:0] pw, input int rsp);
    int e;
    rsp_q.push_back(rsp);
    req_valid = 1'b1;
    req_floor = FW'(f);
    password  = pw;
    @(negedge clk);
    req_valid = 1'b0;
    e = rsp_q.pop_front();
    chk("req_accept", 32'(req_accept), 32'(e == 1));
    chk("req_reject", 32'(req_reject), 32'(e == 0));
  endtask

  task automatic run_trip(input int exp_mv, input int exp_dr, input string tag);
    int mv, dr, n;
    mv = 0; dr = 0; n = 0;
    while (!door_open && n < 400) begin
      if (up || down) mv++;
      @(negedge clk);
      n++;
    end
    while (door_open && n < 400) begin
      dr++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_move_cycles"}, mv, exp_mv);
    chk({tag, "_door_cycles"}, dr, exp_dr);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(!up && !down && !door_open && pending == '0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < 500), 1);
  endtask

  // Stop-order scoreboard plus per-cycle invariants.
  initial begin
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (rst) begin
        if (door_open && !door_prev) begin
          if (stop_q.size() == 0) chk("stop_unexpected_floor", 32'(current_floor), 32'hFFFF);
          else chk("stop_floor", 32'(current_floor), stop_q.pop_front());
        end
        inv_ok = !(door_open && (up || down)) && !(up && down) && (32'(current_floor) < FLOORS);
        chk("invariants", 32'(inv_ok), 1);
      end
      door_prev = door_open;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, dr, mx, n;
    bit pulse;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_floor", 32'(current_floor), 0);
    chk("rst_motion", {29'd0, door_open, up, down}, 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_pulses", {30'd0, req_accept, req_reject}, 0);
    rst = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // Trip 0 -> 3: 12 cycles moving, 8 cycles dwell.
    stop_q.push_back(3);
    send(3, PW, 1);
    run_trip(12, 8, "t1");
    chk("t1_floor", 32'(current_floor), 3);
    chk("t1_pending", 32'(pending), 0);

    // SCAN: 5 above served before 1 below.
    stop_q.push_back(5);
    stop_q.push_back(1);
    send(5, PW, 1);
    send(1, PW, 1);
    wait_idle("t2");
    chk("t2_floor", 32'(current_floor), 1);

    // Accept clears the fail count; third consecutive bad password locks.
    send(2, BADPW, 0);
    send(2, BADPW, 0);
    stop_q.push_back(1);
    send(1, PW, 1);
    chk("t3_reopen_pending", 32'(pending), 0);
    send(3, BADPW, 0);
    send(3, BADPW, 0);
    chk("t3_not_locked_yet", 32'(locked), 0);
    send(3, BADPW, 0);
    chk("t3_locked", 32'(locked), 1);
    chk("t3_ready_low", 32'(req_ready), 0);
    cnt = 0;
    pulse = 1'b0;
    while (locked && cnt < 200) begin
      cnt++;
      req_valid = 1'b1; req_floor = 3'd4; password = PW;
      @(negedge clk);
      pulse = pulse | req_accept | req_reject;
    end
    req_valid = 1'b0;
    chk("t3_lock_cycles", cnt, 64);
    chk("t3_no_pulse_locked", 32'(pulse), 0);
    stop_q.push_back(4);
    send(4, PW, 1);
    chk("t3_pending_after_lock", 32'(pending), 32'h10);
    wait_idle("t3");
    chk("t3_floor", 32'(current_floor), 4);

    // Out-of-range floors reject without counting fails; same-floor request reopens the door.
    send(2, BADPW, 0);
    send(2, BADPW, 0);
    send(6, BADPW, 0);
    send(7, PW, 0);
    chk("t4_range_no_fail", 32'(locked), 0);
    chk("t4_range_pending", 32'(pending), 0);
    stop_q.push_back(4);
    send(4, PW, 1);
    chk("t4_reopen_door", 32'(door_open), 1);
    chk("t4_reopen_pending", 32'(pending), 0);
    repeat (3) @(negedge clk);
    send(4, PW, 1);
    dr = 0;
    while (door_open && dr < 100) begin
      dr++;
      @(negedge clk);
    end
    chk("t4_dwell_restart", dr, 8);

    // Asynchronous reset in the middle of an upward move.
    send(5, PW, 1);
    send(2, PW, 1);
    chk("t5_moving", 32'(up), 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_floor", 32'(current_floor), 0);
    chk("t5_rst_motion", {29'd0, door_open, up, down}, 0);
    chk("t5_rst_pending", 32'(pending), 0);
    chk("t5_rst_pulses", {30'd0, req_accept, req_reject}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stop_q.push_back(2);
    send(2, PW, 1);
    run_trip(8, 8, "t5");
    chk("t5_floor", 32'(current_floor), 2);

`ifdef FIRE_RECALL_EN
    stop_q.push_back(4);
    send(4, PW, 1);
    run_trip(8, 8, "t6a");
    send(5, PW, 1);
    @(negedge clk);
    chk("t6_moving_up", 32'(up), 1);
    fire_recall = 1'b1;
    stop_q.push_back(0);
    mx = 0;
    n = 0;
    while (!door_open && n < 200) begin
      if (int'(current_floor) > mx) mx = int'(current_floor);
      @(negedge clk);
      n++;
    end
    chk("t6_finished_step", mx, 5);
    chk("t6_pending_clear", 32'(pending), 0);
    repeat (20) @(negedge clk);
    chk("t6_door_held", 32'(door_open), 1);
    send(0, PW, 0);
    send(1, BADPW, 0);
    send(1, BADPW, 0);
    send(1, BADPW, 0);
    chk("t6_no_lock", 32'(locked), 0);
    chk("t6_floor0", 32'(current_floor), 0);
    fire_recall = 1'b0;
    dr = 0;
    while (door_open && dr < 100) begin
      dr++;
      @(negedge clk);
    end
    chk("t6_release_dwell", dr, 8);
`endif

    repeat (2) @(negedge clk);
    chk("stops_all_served", stop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
